// File: rtl/exec_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl_pkg
// Description : Shared types and op-flag helpers for the execute controller.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_ctrl_pkg;

    localparam int c_XLEN   = 32;
    localparam int c_REG_AW = 5;

    typedef struct packed {
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
        logic beq;
        logic bne;
        logic blt;
        logic bge;
        logic bltu;
        logic bgeu;
        logic load;
        logic store;
        logic op_imm;
        logic op_reg;
        logic op_m;
        logic fence;
        logic ecall;
        logic ebreak;
        logic csr;
    } op_flags_t;

    typedef struct packed {
        op_flags_t             op;
        logic [c_REG_AW-1:0]   rs1;
        logic [c_REG_AW-1:0]   rs2;
        logic [c_REG_AW-1:0]   rd;
        logic [c_XLEN-1:0]     pc;
        logic [c_XLEN-1:0]     imm;
    } instructions;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } exec_state_t;

    function automatic logic is_branch(input op_flags_t op);
        return op.beq | op.bne | op.blt | op.bge | op.bltu | op.bgeu;
    endfunction

    function automatic logic writes_rd(input instructions ins);
        return (ins.op.lui | ins.op.auipc | ins.op.jal | ins.op.jalr |
                ins.op.op_imm | ins.op.op_reg | ins.op.op_m) && (ins.rd != '0);
    endfunction

    function automatic logic is_unsupported(input op_flags_t op);
        return op.load | op.store | op.fence | op.ecall | op.ebreak | op.csr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_ctrl_next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl_next_pc_calc
// Description : Combinational next-PC (word index) from instruction, rs1 and
//               ALU result (bit 0 = branch taken).
// Revision    : 1.0 - initial release
// ============================================================================
module exec_ctrl_next_pc_calc
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN = c_XLEN
) (
    input  instructions       instr,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   alu_rd,
    output logic [XLEN-1:0]   pc_next
);

    logic signed [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0]        w_off;
    logic [XLEN-1:0]        w_pc_inc;
    logic [XLEN-1:0]        w_pc_rel;
    logic [XLEN-1:0]        w_jalr_sum;
    logic [XLEN-1:0]        w_jalr_tgt;
    logic                   w_unused;

    // Signed shift kept in its own assignment so it cannot collapse to logical.
    assign w_imm_s    = $signed(instr.imm);
    assign w_off      = w_imm_s >>> 2;
    assign w_pc_inc   = instr.pc + XLEN'(1);
    assign w_pc_rel   = instr.pc + w_off;
    assign w_jalr_sum = rs1 + instr.imm;
    assign w_jalr_tgt = w_jalr_sum & ~XLEN'(1);

    always_comb begin
        pc_next = w_pc_inc;
        if (instr.op.jal) begin
            pc_next = w_pc_rel;
        end else if (instr.op.jalr) begin
            pc_next = w_jalr_tgt >> 2;
        end else if (is_branch(instr.op) && alu_rd[0]) begin
            pc_next = w_pc_rel;
        end
    end

    assign w_unused = &{1'b0, alu_rd[XLEN-1:1], instr.rs1, instr.rs2, instr.rd};

endmodule
`default_nettype wire

// File: rtl/exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl
// Description : Execute-stage controller: decode handshake, register read,
//               ALU enabled/completed wait, writeback and next-PC issue.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN        = c_XLEN,
    parameter int REG_AW      = c_REG_AW,
    parameter int ALU_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  instructions         dec_instr,
    output logic [REG_AW-1:0]   rf_rs1_addr,
    output logic [REG_AW-1:0]   rf_rs2_addr,
    input  logic [XLEN-1:0]     rf_rs1_data,
    input  logic [XLEN-1:0]     rf_rs2_data,
    output logic                alu_enabled,
    output instructions         alu_instr,
    output logic [XLEN-1:0]     alu_rs1,
    output logic [XLEN-1:0]     alu_rs2,
    input  logic                alu_completed,
    input  logic [XLEN-1:0]     alu_rd,
    output logic                wb_en,
    output logic [REG_AW-1:0]   wb_addr,
    output logic [XLEN-1:0]     wb_data,
    output logic                pc_valid,
    output logic [XLEN-1:0]     pc_next,
    output logic                unsupported,
    output logic                timeout
);

    localparam int c_WAIT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT + 1) : 1;

    exec_state_t          r_state;
    instructions          r_instr;
    logic [XLEN-1:0]      r_rs1;
    logic [XLEN-1:0]      r_rs2;
    logic [c_WAIT_W-1:0]  r_wait;
    logic [XLEN-1:0]      w_pc_next;
    logic                 w_timeout_hit;

    // The register file reads synchronously, so the address must be live
    // during the accept cycle for data to be ready in READ.
    assign rf_rs1_addr = (r_state == IDLE) ? dec_instr.rs1 : r_instr.rs1;
    assign rf_rs2_addr = (r_state == IDLE) ? dec_instr.rs2 : r_instr.rs2;

    assign alu_instr = r_instr;
    assign alu_rs1   = r_rs1;
    assign alu_rs2   = r_rs2;

    generate
        if (ALU_TIMEOUT > 0) begin : g_timeout
            assign w_timeout_hit = (r_wait == c_WAIT_W'(ALU_TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    exec_ctrl_next_pc_calc #(
        .XLEN    (XLEN)
    ) u_next_pc (
        .instr   (r_instr),
        .rs1     (r_rs1),
        .alu_rd  (alu_rd),
        .pc_next (w_pc_next)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state     <= IDLE;
            r_instr     <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_wait      <= '0;
            dec_ready   <= 1'b1;
            alu_enabled <= 1'b0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            pc_valid    <= 1'b0;
            pc_next     <= '0;
            unsupported <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            wb_en       <= 1'b0;
            pc_valid    <= 1'b0;
            unsupported <= 1'b0;
            timeout     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (dec_valid) begin
                        r_instr   <= dec_instr;
                        dec_ready <= 1'b0;
                        r_state   <= READ;
                    end
                end
                READ: begin
                    r_rs1 <= (r_instr.rs1 == '0) ? '0 : rf_rs1_data;
                    r_rs2 <= (r_instr.rs2 == '0) ? '0 : rf_rs2_data;
                    if (is_unsupported(r_instr.op)) begin
                        r_state     <= WB;
                        pc_valid    <= 1'b1;
                        unsupported <= 1'b1;
                        wb_addr     <= r_instr.rd;
                        pc_next     <= w_pc_next;
                    end else begin
                        r_state     <= EXEC;
                        alu_enabled <= 1'b1;
                        r_wait      <= '0;
                    end
                end
                EXEC: begin
                    if (alu_completed) begin
                        r_state     <= WB;
                        alu_enabled <= 1'b0;
                        pc_valid    <= 1'b1;
                        wb_en       <= writes_rd(r_instr);
                        wb_addr     <= r_instr.rd;
                        wb_data     <= alu_rd;
                        pc_next     <= w_pc_next;
                    end else if (w_timeout_hit) begin
                        r_state     <= IDLE;
                        alu_enabled <= 1'b0;
                        dec_ready   <= 1'b1;
                        timeout     <= 1'b1;
                    end else begin
                        r_wait      <= r_wait + c_WAIT_W'(1);
                    end
                end
                WB: begin
                    r_state   <= IDLE;
                    dec_ready <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    dec_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_exec_ctrl
// Description : Scoreboard testbench for exec_ctrl (plus a timeout instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    typedef struct {
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic [31:0] pc_next;
        logic        unsup;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        dec_valid, dec_ready;
    instructions dec_instr, alu_instr;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr, wb_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data, alu_rs1, alu_rs2, alu_rd, wb_data, pc_next;
    logic        alu_enabled, alu_completed, wb_en, pc_valid, unsupported, timeout;

    logic        dec_valid_t, dec_ready_t, alu_enabled_t, wb_en_t, pc_valid_t;
    logic        unsupported_t, timeout_t;
    logic        alu_never = 1'b0;
    instructions alu_instr_t;
    logic [4:0]  rf_rs1_addr_t, rf_rs2_addr_t, wb_addr_t;
    logic [31:0] alu_rs1_t, alu_rs2_t, wb_data_t, pc_next_t;

    exec_ctrl u_dut (
        .clk(clk), .rstn(rstn), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .alu_enabled(alu_enabled), .alu_instr(alu_instr), .alu_rs1(alu_rs1),
        .alu_rs2(alu_rs2), .alu_completed(alu_completed), .alu_rd(alu_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .pc_valid(pc_valid),
        .pc_next(pc_next), .unsupported(unsupported), .timeout(timeout)
    );

    exec_ctrl #(.ALU_TIMEOUT(3)) u_dut_to (
        .clk(clk), .rstn(rstn), .dec_valid(dec_valid_t), .dec_ready(dec_ready_t),
        .dec_instr(dec_instr), .rf_rs1_addr(rf_rs1_addr_t), .rf_rs2_addr(rf_rs2_addr_t),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .alu_enabled(alu_enabled_t), .alu_instr(alu_instr_t), .alu_rs1(alu_rs1_t),
        .alu_rs2(alu_rs2_t), .alu_completed(alu_never), .alu_rd(alu_rd),
        .wb_en(wb_en_t), .wb_addr(wb_addr_t), .wb_data(wb_data_t), .pc_valid(pc_valid_t),
        .pc_next(pc_next_t), .unsupported(unsupported_t), .timeout(timeout_t)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    exp_t        sb[$];
    logic [31:0] rf [32];
    logic [31:0] cur_res, cur_e1, cur_e2, snap1, snap2;
    int          cur_delay = 0;
    int          exec_cnt  = 0;
    int          alu_en_cycles = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic en, input logic [4:0] a, input logic [31:0] d,
                                    input logic [31:0] pc, input logic un, input int lat);
        exp_t e;
        e.wb_en = en; e.wb_addr = a; e.wb_data = d; e.pc_next = pc;
        e.unsup = un; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Synchronous-read register file
    initial forever begin
        @(posedge clk);
        rf_rs1_data <= rf[rf_rs1_addr];
        rf_rs2_data <= rf[rf_rs2_addr];
    end

    // ALU responder: completes cur_delay cycles into EXEC, checks operands
    initial begin
        alu_completed = 1'b0;
        alu_rd = '0;
        forever begin
            @(negedge clk);
            if (alu_enabled) begin
                alu_en_cycles++;
                check("dec_ready_busy", dec_ready, 1'b0);
                if (exec_cnt == 0) begin
                    snap1 = alu_rs1;
                    snap2 = alu_rs2;
                    check("alu_rs1", alu_rs1, cur_e1);
                    check("alu_rs2", alu_rs2, cur_e2);
                end else begin
                    check("alu_rs1_stable", alu_rs1, snap1);
                    check("alu_rs2_stable", alu_rs2, snap2);
                end
                alu_completed = (exec_cnt == cur_delay);
                alu_rd = cur_res;
                exec_cnt++;
            end else begin
                alu_completed = 1'b0;
                exec_cnt = 0;
            end
        end
    end

    // Writeback monitor
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rstn) begin
            if (pc_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_pc_valid", pc_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("wb_en", wb_en, e.wb_en);
                    if (e.wb_en) begin
                        check("wb_addr", wb_addr, e.wb_addr);
                        check("wb_data", wb_data, e.wb_data);
                    end
                    check("pc_next", pc_next, e.pc_next);
                    check("unsupported", unsupported, e.unsup);
                    check("latency", cyc - e.acc, e.lat);
                end
            end else begin
                check("wb_en_no_pc_valid", wb_en, 1'b0);
            end
        end
    end

    task automatic issue(input instructions ins, input logic [31:0] res, input int dly,
                         input logic [31:0] e1, input logic [31:0] e2,
                         input exp_t e, input bit push);
        @(negedge clk);
        cur_res = res; cur_delay = dly; cur_e1 = e1; cur_e2 = e2;
        check("dec_ready_idle", dec_ready, 1'b1);
        dec_instr = ins;
        dec_valid = 1'b1;
        e.acc = cyc;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1 dec_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && dec_ready) break;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        instructions ins;
        int n0, acc, to_cnt, to_cyc, wbs;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * i;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'hFFFF_FFFF; rf[4] = 32'h103;
        rstn = 1'b1; dec_valid = 1'b0; dec_valid_t = 1'b0; dec_instr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dec_ready", dec_ready, 1'b1);
        check("rst_alu_enabled", alu_enabled, 1'b0);
        check("rst_wb_en", wb_en, 1'b0);
        check("rst_pc_valid", pc_valid, 1'b0);
        check("rst_pc_next", pc_next, 32'h0);
        check("rst_unsupported", unsupported, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_alu_instr", alu_instr, '0);
        check("rst_dec_ready_t", dec_ready_t, 1'b1);
        rstn = 1'b0;

        // addi x5,x0,7 @ pc 10
        ins = '0; ins.op.op_imm = 1'b1; ins.rd = 5; ins.pc = 10; ins.imm = 7;
        issue(ins, 32'd7, 0, 32'h0, 32'h0, mk_exp(1'b1, 5'd5, 32'd7, 32'd11, 1'b0, 3), 1'b1);
        drain();
        // add x0,x3,x0: zero-forced x0 operand, no writeback to x0
        ins = '0; ins.op.op_reg = 1'b1; ins.rd = 0; ins.rs1 = 3; ins.pc = 40;
        issue(ins, 32'h1234, 0, 32'hFFFF_FFFF, 32'h0, mk_exp(1'b0, 5'd0, 32'h0, 32'd41, 1'b0, 3), 1'b1);
        drain();
        // beq taken / not taken
        ins = '0; ins.op.beq = 1'b1; ins.rs1 = 1; ins.rs2 = 2; ins.pc = 20; ins.imm = 16;
        issue(ins, 32'd1, 0, 32'h11, 32'h22, mk_exp(1'b0, 5'd0, 32'h0, 32'd24, 1'b0, 3), 1'b1);
        drain();
        issue(ins, 32'd0, 0, 32'h11, 32'h22, mk_exp(1'b0, 5'd0, 32'h0, 32'd21, 1'b0, 3), 1'b1);
        drain();
        // jal x1, -8 @ pc 8
        ins = '0; ins.op.jal = 1'b1; ins.rd = 1; ins.pc = 8; ins.imm = 32'hFFFF_FFF8;
        issue(ins, 32'd9, 0, 32'h0, 32'h0, mk_exp(1'b1, 5'd1, 32'd9, 32'd6, 1'b0, 3), 1'b1);
        drain();
        // jalr x2, 1(x4), x4 = 0x103
        ins = '0; ins.op.jalr = 1'b1; ins.rd = 2; ins.rs1 = 4; ins.pc = 50; ins.imm = 1;
        issue(ins, 32'd51, 0, 32'h103, 32'h0, mk_exp(1'b1, 5'd2, 32'd51, 32'h41, 1'b0, 3), 1'b1);
        drain();
        // M-ext op with ALU completing 5 cycles late
        ins = '0; ins.op.op_m = 1'b1; ins.rd = 7; ins.rs1 = 3; ins.rs2 = 4; ins.pc = 100;
        issue(ins, 32'hABCD, 5, 32'hFFFF_FFFF, 32'h103,
              mk_exp(1'b1, 5'd7, 32'hABCD, 32'd101, 1'b0, 8), 1'b1);
        drain();
        // lw: skips EXEC entirely
        n0 = alu_en_cycles;
        ins = '0; ins.op.load = 1'b1; ins.rd = 6; ins.rs1 = 1; ins.pc = 30; ins.imm = 4;
        issue(ins, 32'h0, 0, 32'h0, 32'h0, mk_exp(1'b0, 5'd0, 32'h0, 32'd31, 1'b1, 2), 1'b1);
        drain();
        check("lw_no_alu", alu_en_cycles - n0, 0);
        // lui x0 suppresses writeback
        ins = '0; ins.op.lui = 1'b1; ins.rd = 0; ins.pc = 60; ins.imm = 32'h5000;
        issue(ins, 32'h5000, 0, 32'h0, 32'h0, mk_exp(1'b0, 5'd0, 32'h0, 32'd61, 1'b0, 3), 1'b1);
        drain();
        // taken branch wrapping below PC 0
        ins = '0; ins.op.bne = 1'b1; ins.pc = 0; ins.imm = 32'hFFFF_FFFC;
        issue(ins, 32'd1, 1, 32'h0, 32'h0, mk_exp(1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 4), 1'b1);
        drain();

        // Reset during EXEC drops the instruction
        ins = '0; ins.op.op_imm = 1'b1; ins.rd = 8; ins.pc = 70;
        issue(ins, 32'h77, 100, 32'h0, 32'h0, mk_exp(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 0), 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (alu_enabled) break;
            @(negedge clk);
        end
        check("rst_reach_exec", alu_enabled, 1'b1);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_alu_enabled", alu_enabled, 1'b0);
        check("midrst_dec_ready", dec_ready, 1'b1);
        check("midrst_wb_en", wb_en, 1'b0);
        check("midrst_pc_valid", pc_valid, 1'b0);
        rstn = 1'b0;
        repeat (4) @(negedge clk);
        ins = '0; ins.op.auipc = 1'b1; ins.rd = 9; ins.pc = 80;
        issue(ins, 32'h99, 0, 32'h0, 32'h0, mk_exp(1'b1, 5'd9, 32'h99, 32'd81, 1'b0, 3), 1'b1);
        drain();

        // Timeout instance: ALU never completes, ALU_TIMEOUT = 3
        @(negedge clk);
        ins = '0; ins.op.op_imm = 1'b1; ins.rd = 5; ins.pc = 90;
        dec_instr = ins;
        dec_valid_t = 1'b1;
        acc = cyc;
        @(posedge clk);
        #1 dec_valid_t = 1'b0;
        to_cnt = 0; to_cyc = -1; wbs = 0;
        repeat (15) begin
            @(negedge clk);
            if (timeout_t) begin to_cnt++; to_cyc = cyc; end
            if (wb_en_t || pc_valid_t) wbs++;
        end
        check("timeout_pulses", to_cnt, 1);
        check("timeout_cycle", to_cyc - acc, 5);
        check("timeout_no_wb", wbs, 0);
        check("timeout_idle", dec_ready_t, 1'b1);
        check("timeout_alu_off", alu_enabled_t, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
